// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch with decode handshake
module instr_fetch_unit #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 9,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc_in,
  input  logic               redirect,
  input  logic               halt,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [31:0]        instr_pc,
  output logic               instr_valid,
  input  logic               dec_ready,
  output logic               pc_advance,
  output logic               halted,
  output logic               fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic [2:0]       state;
  logic [31:0]      req_pc;
  logic             drop;
  logic             halt_pending;
  logic [CNT_W-1:0] cnt;
  logic             pc_oob;

  assign pc_oob     = |pc_in[31:ADDR_W];
  assign imem_req   = (state == S_REQ) && !pc_oob;
  assign imem_addr  = imem_req ? pc_in[ADDR_W-1:0] : '0;
  assign pc_advance = (state == S_HOLD) && instr_valid && dec_ready && !redirect;
  assign halted     = (state == S_HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      req_pc       <= '0;
      drop         <= 1'b0;
      halt_pending <= 1'b0;
      cnt          <= '0;
      instr_out    <= '0;
      instr_pc     <= '0;
      instr_valid  <= 1'b0;
      fault        <= 1'b0;
    end else begin
      if (halt) halt_pending <= 1'b1;
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (pc_oob) begin
            fault <= 1'b1;
            state <= S_HALTED;
          end else begin
            req_pc <= pc_in;
            cnt    <= '0;
            drop   <= redirect;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A redirect coinciding with the data beat also makes that data stale.
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (drop || redirect) begin
              state <= S_REQ;
            end else begin
              instr_out   <= imem_rdata;
              instr_pc    <= req_pc;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end
          end else if (cnt == CNT_LAST) begin
            fault <= 1'b1;
            state <= S_HALTED;
          end else begin
            cnt <= cnt + 1'b1;
            if (redirect) drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            state       <= S_REQ;
          end else if (dec_ready) begin
            instr_valid <= 1'b0;
            state       <= (halt || halt_pending) ? S_HALTED : S_REQ;
          end
        end
        S_HALTED: instr_valid <= 1'b0;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        redirect;
  logic        halt;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [8:0]  imem_rdata;
  logic        imem_rvalid;
  logic [8:0]  instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic        pc_advance;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.ADDR_W(12), .INSTR_W(9), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .redirect(redirect), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_rvalid(imem_rvalid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .dec_ready(dec_ready), .pc_advance(pc_advance),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"}, {20'd0, imem_addr}, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_adv"}, {31'd0, pc_advance}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_fault"}, {31'd0, fault}, 32'd0);
    check({tag, "_out"}, {23'd0, instr_out}, 32'd0);
    check({tag, "_ipc"}, instr_pc, 32'd0);
  endtask

  // Leaves the bench in cycle 1 (IDLE) after release.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pc_in = 32'd0; redirect = 1'b0; halt = 1'b0;
    imem_rdata = '0; imem_rvalid = 1'b0; dec_ready = 1'b1;
    @(posedge clk);
    do_reset("rst0");

    // Basic fetch: request in cycle 2, instruction in cycle 4
    check("c1_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("c2_req", {31'd0, imem_req}, 32'd1);
    check("c2_addr", {20'd0, imem_addr}, 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 9'h1A3;
    check("c3_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 1'b0;
    check("c4_valid", {31'd0, instr_valid}, 32'd1);
    check("c4_out", {23'd0, instr_out}, 32'h1A3);
    check("c4_ipc", instr_pc, 32'd0);
    check("c4_adv", {31'd0, pc_advance}, 32'd1);
    pc_in = 32'd1;
    tick();
    check("c5_req", {31'd0, imem_req}, 32'd1);
    check("c5_addr", {20'd0, imem_addr}, 32'd1);

    // Decode stall for 5 cycles
    dec_ready = 1'b0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 9'h055;
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_out", {23'd0, instr_out}, 32'h055);
      check("stall_adv", {31'd0, pc_advance}, 32'd0);
      tick();
    end
    dec_ready = 1'b1;
    #1;
    check("stall_rel_adv", {31'd0, pc_advance}, 32'd1);
    check("stall_rel_ipc", instr_pc, 32'd1);
    tick();
    check("stall_post_adv", {31'd0, pc_advance}, 32'd0);
    check("stall_post_valid", {31'd0, instr_valid}, 32'd0);

    // Redirect during WAIT: data for PC 5 dropped, refetch at 40
    pc_in = 32'd5;
    #1;
    check("rw_addr5", {20'd0, imem_addr}, 32'd5);
    tick();
    redirect = 1'b1;
    check("rw_wait_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0; pc_in = 32'd40;
    imem_rvalid = 1'b1; imem_rdata = 9'h0AA;
    check("rw_adv_stale", {31'd0, pc_advance}, 32'd0);
    tick();
    imem_rvalid = 1'b0;
    check("rw_dropped_valid", {31'd0, instr_valid}, 32'd0);
    check("rw_req40", {31'd0, imem_req}, 32'd1);
    check("rw_addr40", {20'd0, imem_addr}, 32'd40);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 9'h123;
    tick();
    imem_rvalid = 1'b0;
    check("rw_valid", {31'd0, instr_valid}, 32'd1);
    check("rw_ipc", instr_pc, 32'd40);
    check("rw_out", {23'd0, instr_out}, 32'h123);
    check("rw_adv", {31'd0, pc_advance}, 32'd1);
    pc_in = 32'd41;
    tick();

    // Redirect and dec_ready together in HOLD: redirect wins
    check("rh_addr41", {20'd0, imem_addr}, 32'd41);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 9'h0F0;
    tick();
    imem_rvalid = 1'b0;
    redirect = 1'b1; dec_ready = 1'b1;
    #1;
    check("rh_adv", {31'd0, pc_advance}, 32'd0);
    pc_in = 32'd100;
    tick();
    redirect = 1'b0;
    check("rh_valid", {31'd0, instr_valid}, 32'd0);
    check("rh_req", {31'd0, imem_req}, 32'd1);
    check("rh_addr100", {20'd0, imem_addr}, 32'd100);

    // Halt raised during WAIT: instruction still delivered, then HALTED
    tick();
    halt = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 9'h1FF;
    tick();
    halt = 1'b0; imem_rvalid = 1'b0;
    check("ht_valid", {31'd0, instr_valid}, 32'd1);
    check("ht_out", {23'd0, instr_out}, 32'h1FF);
    check("ht_adv", {31'd0, pc_advance}, 32'd1);
    tick();
    check("ht_halted", {31'd0, halted}, 32'd1);
    check("ht_valid0", {31'd0, instr_valid}, 32'd0);
    check("ht_fault0", {31'd0, fault}, 32'd0);
    tick();
    check("ht_noreq", {31'd0, imem_req}, 32'd0);
    check("ht_still", {31'd0, halted}, 32'd1);

    // Out-of-range PC
    pc_in = 32'd4096;
    do_reset("rst1");
    tick();
    check("oob_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    check("oob_fault", {31'd0, fault}, 32'd1);
    check("oob_halted", {31'd0, halted}, 32'd1);

    // Data on the 16th WAIT cycle is still accepted
    pc_in = 32'd3;
    do_reset("rst2");
    tick();
    check("late_addr", {20'd0, imem_addr}, 32'd3);
    for (int i = 0; i < 16; i++) tick();
    imem_rvalid = 1'b1; imem_rdata = 9'h0C3;
    tick();
    imem_rvalid = 1'b0;
    check("late_valid", {31'd0, instr_valid}, 32'd1);
    check("late_out", {23'd0, instr_out}, 32'h0C3);
    check("late_fault", {31'd0, fault}, 32'd0);

    // Timeout: 16 WAIT cycles without rvalid
    pc_in = 32'd7;
    do_reset("rst3");
    tick();
    check("to_addr", {20'd0, imem_addr}, 32'd7);
    for (int i = 0; i < 16; i++) tick();
    check("to_edge_halted", {31'd0, halted}, 32'd0);
    check("to_edge_fault", {31'd0, fault}, 32'd0);
    tick();
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_halted", {31'd0, halted}, 32'd1);

    // Reset mid-WAIT, stale rvalid afterwards is ignored
    pc_in = 32'd9;
    do_reset("rst4");
    tick();
    check("mw_req", {31'd0, imem_req}, 32'd1);
    tick();
    tick();
    do_reset("rst5");
    imem_rvalid = 1'b1; imem_rdata = 9'h111;
    tick();
    imem_rvalid = 1'b0;
    check("mw_fresh_req", {31'd0, imem_req}, 32'd1);
    check("mw_fresh_addr", {20'd0, imem_addr}, 32'd9);
    check("mw_no_stale", {31'd0, instr_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
